rio_link_rx_ctrl: RTL and testbench

GTP receive controller, the far end of the link transmit controller. It takes registered 16-bit RocketIO/GTP receive words plus their K-flags and decodes SYNC, SOP, data, EOP and credit words. It produces a user packet stream (valid/sop/eop/data), upstream credit pulses for the local transmit side, and link-up status. It sits between the GTP wrapper and the link-level buffers.

---
 rtl/rio_link_rx_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_rio_link_rx_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rio_link_rx_ctrl.sv
// GTP receive controller: decodes registered RocketIO words into link status,
// peer credits and a user packet stream. One data word is held so EOP can tag it.
module rio_link_rx_ctrl #(
    parameter int         DATA_WIDTH     = 16,
    parameter int         CREDIT_WIDTH   = 16,
    parameter logic [7:0] RIO_COMMA_CHAR = 8'hbc,
    parameter logic [7:0] RIO_SYN_CHAR   = 8'hf7,
    parameter logic [7:0] RIO_SKP_CHAR   = 8'hfb,
    parameter logic [7:0] RIO_SOP_CHAR   = 8'hfd,
    parameter logic [7:0] RIO_EOP_CHAR   = 8'hfe,
    parameter int         SYNC_COUNT     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_rio_rx_data,
    input  logic [1:0]              i_rio_rx_isk,
    input  logic                    i_rio_rx_err,
    input  logic                    i_rio_rx_aligned,
    output logic                    o_link_up,
    output logic                    o_sync_seen,
    output logic [CREDIT_WIDTH-1:0] o_ds_credit,
    output logic                    o_ds_credit_valid,
    output logic                    o_rx_valid,
    output logic                    o_rx_sop,
    output logic                    o_rx_eop,
    output logic [DATA_WIDTH-1:0]   o_rx_data,
    output logic                    o_rx_err
);

    localparam logic       LINK_DOWN = 1'b0;
    localparam logic       LINK_UP   = 1'b1;
    localparam logic       OUT_PKT   = 1'b0;
    localparam logic       IN_PKT    = 1'b1;
    localparam logic [7:0] SYNC_MAX  = SYNC_COUNT[7:0];

    logic [DATA_WIDTH-1:0]   data_q;
    logic [1:0]              isk_q;
    logic                    err_q, aligned_q;
    logic                    link_q, link_d;
    logic                    pkt_q, pkt_d;
    logic                    first_q, first_d;
    logic                    hold_v_q, hold_v_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              cnt_inc;
    logic                    sync_q, sync_d;
    logic [CREDIT_WIDTH-1:0] cred_q, cred_d;
    logic                    cred_v_q, cred_v_d;
    logic                    rx_v_q, rx_v_d;
    logic                    sop_q, sop_d;
    logic                    eop_q, eop_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;

    logic ctrl_w, data_w, bad_w, syn_w, sop_w, eop_w, drop_w;
    logic [7:0] char_hi;

    assign char_hi = data_q[15:8];
    assign ctrl_w  = (isk_q == 2'b11) && (data_q[7:0] == RIO_COMMA_CHAR) &&
                     ((char_hi == RIO_SYN_CHAR) || (char_hi == RIO_SKP_CHAR) ||
                      (char_hi == RIO_SOP_CHAR) || (char_hi == RIO_EOP_CHAR));
    assign data_w  = (isk_q == 2'b00) && !err_q;
    assign bad_w   = err_q || !(ctrl_w || data_w);
    assign syn_w   = ctrl_w && !err_q && (char_hi == RIO_SYN_CHAR);
    assign sop_w   = ctrl_w && !err_q && (char_hi == RIO_SOP_CHAR);
    assign eop_w   = ctrl_w && !err_q && (char_hi == RIO_EOP_CHAR);
    assign drop_w  = bad_w || !aligned_q;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        link_d   = link_q;
        cnt_d    = cnt_q;
        pkt_d    = pkt_q;
        first_d  = first_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        sync_d   = syn_w;
        cred_v_d = 1'b0;
        cred_d   = cred_q;
        rx_v_d   = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = 1'b0;
        if (link_q == LINK_DOWN) begin
            if (drop_w) begin
                cnt_d = '0;
            end else if (syn_w) begin
                if (cnt_inc == SYNC_MAX) begin
                    cnt_d  = '0;
                    link_d = LINK_UP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end else if (drop_w) begin
            // Flush a held word as a truncated packet so downstream sees an end.
            link_d = LINK_DOWN;
            rerr_d = 1'b1;
            if (pkt_q == IN_PKT && hold_v_q) begin
                rx_v_d  = 1'b1;
                sop_d   = first_q;
                eop_d   = 1'b1;
                rdata_d = hold_q;
            end
            pkt_d    = OUT_PKT;
            hold_v_d = 1'b0;
            first_d  = 1'b0;
        end else if (pkt_q == OUT_PKT) begin
            if (sop_w) begin
                pkt_d    = IN_PKT;
                first_d  = 1'b1;
                hold_v_d = 1'b0;
            end else if (data_w) begin
                cred_v_d = 1'b1;
                cred_d   = data_q[CREDIT_WIDTH-1:0];
            end else if (eop_w) begin
                rerr_d = 1'b1;
            end
        end else begin
            if (data_w) begin
                if (hold_v_q) begin
                    rx_v_d  = 1'b1;
                    sop_d   = first_q;
                    rdata_d = hold_q;
                    first_d = 1'b0;
                end
                hold_d   = data_q;
                hold_v_d = 1'b1;
            end else if (eop_w) begin
                if (hold_v_q) begin
                    rx_v_d  = 1'b1;
                    sop_d   = first_q;
                    eop_d   = 1'b1;
                    rdata_d = hold_q;
                end else begin
                    rerr_d = 1'b1;
                end
                pkt_d    = OUT_PKT;
                hold_v_d = 1'b0;
            end else if (sop_w) begin
                if (hold_v_q) begin
                    rx_v_d  = 1'b1;
                    sop_d   = first_q;
                    eop_d   = 1'b1;
                    rdata_d = hold_q;
                    rerr_d  = 1'b1;
                end
                first_d  = 1'b1;
                hold_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            isk_q     <= '0;
            err_q     <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            data_q    <= i_rio_rx_data;
            isk_q     <= i_rio_rx_isk;
            err_q     <= i_rio_rx_err;
            aligned_q <= i_rio_rx_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_q   <= LINK_DOWN;
            cnt_q    <= '0;
            pkt_q    <= OUT_PKT;
            first_q  <= 1'b0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            sync_q   <= 1'b0;
            cred_q   <= '0;
            cred_v_q <= 1'b0;
            rx_v_q   <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            link_q   <= link_d;
            cnt_q    <= cnt_d;
            pkt_q    <= pkt_d;
            first_q  <= first_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            sync_q   <= sync_d;
            cred_q   <= cred_d;
            cred_v_q <= cred_v_d;
            rx_v_q   <= rx_v_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    assign o_link_up         = link_q;
    assign o_sync_seen       = sync_q;
    assign o_ds_credit       = cred_q;
    assign o_ds_credit_valid = cred_v_q;
    assign o_rx_valid        = rx_v_q;
    assign o_rx_sop          = sop_q;
    assign o_rx_eop          = eop_q;
    assign o_rx_data         = rdata_q;
    assign o_rx_err          = rerr_q;

endmodule

// File: tb/tb_rio_link_rx_ctrl.sv
// Bench for rio_link_rx_ctrl: directed protocol sequences plus random traffic,
// each word's outputs predicted by a packet-level model two cycles later.
module tb_rio_link_rx_ctrl;

  localparam int SYNC_N = 4;
  localparam logic [15:0] W_SYN = 16'hf7bc;
  localparam logic [15:0] W_SKP = 16'hfbbc;
  localparam logic [15:0] W_SOP = 16'hfdbc;
  localparam logic [15:0] W_EOP = 16'hfebc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_rio_rx_data = '0;
  logic [1:0]  i_rio_rx_isk = '0;
  logic        i_rio_rx_err = 1'b0;
  logic        i_rio_rx_aligned = 1'b0;
  logic        o_link_up, o_sync_seen, o_ds_credit_valid;
  logic [15:0] o_ds_credit;
  logic        o_rx_valid, o_rx_sop, o_rx_eop, o_rx_err;
  logic [15:0] o_rx_data;

  int n_checks = 0;
  int n_errors = 0;

  // {link_up, sync_seen, credit_valid, rx_valid, sop, eop, err, rx_data, credit}
  logic [38:0] exp_q[$];

  // model state
  bit          m_link;
  int          m_syncs;
  bit          m_in_pkt;
  int          m_emitted;
  logic [15:0] m_pend[$];

  rio_link_rx_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rio_rx_data     (i_rio_rx_data),
    .i_rio_rx_isk      (i_rio_rx_isk),
    .i_rio_rx_err      (i_rio_rx_err),
    .i_rio_rx_aligned  (i_rio_rx_aligned),
    .o_link_up         (o_link_up),
    .o_sync_seen       (o_sync_seen),
    .o_ds_credit       (o_ds_credit),
    .o_ds_credit_valid (o_ds_credit_valid),
    .o_rx_valid        (o_rx_valid),
    .o_rx_sop          (o_rx_sop),
    .o_rx_eop          (o_rx_eop),
    .o_rx_data         (o_rx_data),
    .o_rx_err          (o_rx_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [38:0] got, input logic [38:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [38:0] obs_raw();
    return {o_link_up, o_sync_seen, o_ds_credit_valid, o_rx_valid, o_rx_sop,
            o_rx_eop, o_rx_err, o_rx_data, o_ds_credit};
  endfunction

  function automatic logic [38:0] obs_masked();
    return {o_link_up, o_sync_seen, o_ds_credit_valid, o_rx_valid, o_rx_sop,
            o_rx_eop, o_rx_err, (o_rx_valid ? o_rx_data : 16'h0),
            (o_ds_credit_valid ? o_ds_credit : 16'h0)};
  endfunction

  function automatic void model_reset();
    m_link = 1'b0;
    m_syncs = 0;
    m_in_pkt = 1'b0;
    m_emitted = 0;
    m_pend.delete();
  endfunction

  // Predicts what the outputs show two cycles after this word enters.
  function automatic logic [38:0] model(input logic [15:0] d, input logic [1:0] k,
                                        input logic e, input logic a);
    bit ctrl, dat, bad, syn, sop, eop;
    bit e_sync, e_cv, e_rv, e_sop, e_eop, e_err;
    logic [15:0] e_data, e_cred;
    e_sync = 0; e_cv = 0; e_rv = 0; e_sop = 0; e_eop = 0; e_err = 0;
    e_data = '0; e_cred = '0;
    ctrl = (k == 2'b11) && (d[7:0] == 8'hbc) && (d[15:8] inside {8'hf7, 8'hfb, 8'hfd, 8'hfe});
    dat  = (k == 2'b00);
    bad  = e || !(ctrl || dat);
    syn  = !bad && ctrl && d[15:8] == 8'hf7;
    sop  = !bad && ctrl && d[15:8] == 8'hfd;
    eop  = !bad && ctrl && d[15:8] == 8'hfe;
    dat  = dat && !bad;
    e_sync = syn;
    if (!m_link) begin
      if (bad || !a) m_syncs = 0;
      else if (syn) m_syncs++;
      if (m_syncs == SYNC_N) begin
        m_link = 1'b1;
        m_syncs = 0;
      end
    end else if (bad || !a) begin
      m_link = 1'b0;
      e_err = 1;
      if (m_in_pkt && m_pend.size() > 0) begin
        e_rv = 1; e_eop = 1; e_sop = (m_emitted == 0); e_data = m_pend.pop_front();
      end
      m_in_pkt = 1'b0;
      m_pend.delete();
    end else if (!m_in_pkt) begin
      if (sop) begin
        m_in_pkt = 1'b1;
        m_emitted = 0;
        m_pend.delete();
      end else if (dat) begin
        e_cv = 1; e_cred = d;
      end else if (eop) begin
        e_err = 1;
      end
    end else begin
      if (dat) begin
        m_pend.push_back(d);
        if (m_pend.size() > 1) begin
          e_rv = 1; e_sop = (m_emitted == 0); e_data = m_pend.pop_front();
          m_emitted++;
        end
      end else if (eop) begin
        if (m_pend.size() > 0) begin
          e_rv = 1; e_eop = 1; e_sop = (m_emitted == 0); e_data = m_pend.pop_front();
        end else begin
          e_err = 1;
        end
        m_in_pkt = 1'b0;
        m_pend.delete();
      end else if (sop) begin
        if (m_pend.size() > 0) begin
          e_rv = 1; e_eop = 1; e_err = 1; e_sop = (m_emitted == 0); e_data = m_pend.pop_front();
        end
        m_emitted = 0;
        m_pend.delete();
      end
    end
    return {m_link, e_sync, e_cv, e_rv, e_sop, e_eop, e_err, e_data, e_cred};
  endfunction

  task automatic send(input string tag, input logic [15:0] d, input logic [1:0] k,
                      input logic e, input logic a);
    @(negedge clk);
    if (exp_q.size() >= 2) check_eq(tag, obs_masked(), exp_q.pop_front());
    i_rio_rx_data = d;
    i_rio_rx_isk = k;
    i_rio_rx_err = e;
    i_rio_rx_aligned = a;
    exp_q.push_back(model(d, k, e, a));
  endtask

  task automatic send_ctrl(input string tag, input logic [15:0] w);
    send(tag, w, 2'b11, 1'b0, 1'b1);
  endtask

  task automatic send_data(input string tag, input logic [15:0] w);
    send(tag, w, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_eq(tag, obs_masked(), exp_q.pop_front());
      i_rio_rx_data = W_SKP;
      i_rio_rx_isk = 2'b11;
      i_rio_rx_err = 1'b0;
      i_rio_rx_aligned = 1'b1;
    end
  endtask

  task automatic rand_word();
    int r;
    logic [15:0] d;
    logic [1:0] k;
    logic e;
    logic a;
    r = $urandom_range(0, 99);
    d = 16'($urandom);
    k = 2'b00;
    e = 1'b0;
    a = 1'b1;
    if (r < 14)      begin d = W_SYN; k = 2'b11; end
    else if (r < 19) begin d = W_SKP; k = 2'b11; end
    else if (r < 29) begin d = W_SOP; k = 2'b11; end
    else if (r < 39) begin d = W_EOP; k = 2'b11; end
    else if (r < 41) k = 2'($urandom_range(1, 3));
    else if (r < 42) e = 1'b1;
    else if (r < 43) a = 1'b0;
    send("rand", d, k, e, a);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_state", obs_raw(), 39'h0);
    rst_n = 1'b1;

    // link bring-up with a BAD word interrupting the run
    for (int i = 0; i < 3; i++) send_ctrl("sync_partial", W_SYN);
    send("sync_bad", W_SYN, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < SYNC_N; i++) send_ctrl("sync_up", W_SYN);
    send_ctrl("idle", W_SKP);

    // three-word packet
    send_ctrl("pkt3", W_SOP);
    send_data("pkt3", 16'h1111);
    send_data("pkt3", 16'h2222);
    send_data("pkt3", 16'h3333);
    send_ctrl("pkt3", W_EOP);

    // single-word and empty packets
    send_ctrl("pkt1", W_SOP);
    send_data("pkt1", 16'haaaa);
    send_ctrl("pkt1", W_EOP);
    send_ctrl("pkt0", W_SOP);
    send_ctrl("pkt0", W_EOP);

    // trailing credits and clock-correction inside a packet
    send_ctrl("credit", W_EOP);
    send_data("credit", 16'h0040);
    send_data("credit", 16'h0041);
    send_ctrl("pkt_skp", W_SOP);
    send_data("pkt_skp", 16'h1234);
    send_ctrl("pkt_skp", W_SKP);
    send_data("pkt_skp", 16'h5678);
    send_ctrl("pkt_skp", W_SYN);
    send_data("pkt_skp", 16'h9abc);
    send_ctrl("pkt_skp", W_EOP);

    // abort by a second SOP
    send_ctrl("abort", W_SOP);
    send_data("abort", 16'h0a0a);
    send_data("abort", 16'h0b0b);
    send_ctrl("abort", W_SOP);
    send_data("abort", 16'h0c0c);
    send_ctrl("abort", W_EOP);

    // line error mid-packet drops the link
    send_ctrl("line_err", W_SOP);
    send_data("line_err", 16'h5555);
    send("line_err", 16'h6666, 2'b00, 1'b1, 1'b1);
    send_data("link_down", 16'h7777);
    send_data("link_down", 16'h8888);
    for (int i = 0; i < SYNC_N; i++) send_ctrl("resync", W_SYN);

    // misalignment mid-packet
    send_ctrl("misalign", W_SOP);
    send_data("misalign", 16'h4242);
    send_data("misalign", 16'h4343);
    send("misalign", 16'h4444, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < SYNC_N; i++) send_ctrl("resync2", W_SYN);

    // asynchronous reset while a word is being emitted
    send_ctrl("pre_rst", W_SOP);
    send_data("pre_rst", 16'h0102);
    send_data("pre_rst", 16'h0304);
    send_ctrl("pre_rst", W_SKP);
    send_ctrl("pre_rst", W_SKP);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", obs_raw(), 39'h0);
    exp_q.delete();
    model_reset();
    i_rio_rx_data = '0;
    i_rio_rx_isk = '0;
    i_rio_rx_err = 1'b0;
    i_rio_rx_aligned = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SYNC_N - 1; i++) send_ctrl("post_rst", W_SYN);
    send_data("post_rst", 16'h0099);
    send_ctrl("post_rst", W_SYN);
    send_data("post_rst", 16'h00aa);

    // random traffic
    for (int i = 0; i < 3000; i++) rand_word();
    drain("drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
